// File: rtl/fetch_queue_if.sv
// Handshake and memory bus bundle between the fetch front end, its
// instruction memory, the redirect source and the decode stage.
interface fetch_queue_if #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 32
);
    logic               should_jump;
    logic [PC_W-1:0]    jump_pc;
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;

    // The fetch unit itself.
    modport slave (
        input  should_jump, jump_pc, imem_data, dec_ready,
        output imem_rd_en, imem_addr, dec_valid, dec_instr, dec_pc
    );

    // The environment around the fetch unit (memory, decode, redirect).
    modport master (
        output should_jump, jump_pc, imem_data, dec_ready,
        input  imem_rd_en, imem_addr, dec_valid, dec_instr, dec_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues reads to a synchronous
// instruction memory, buffers returned words in a small prefetch FIFO and
// hands {pc, instr} to decode. A redirect flushes everything in flight.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 5,
    parameter int INSTR_W = 32
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [AW-1:0] ptr_t;

    logic [PC_W-1:0]    fetch_pc_q,   fetch_pc_d;
    logic               pending_q,    pending_d;
    logic [PC_W-1:0]    pending_pc_q, pending_pc_d;
    ptr_t               wr_ptr_q,     wr_ptr_d;
    ptr_t               rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]      count_q,      count_d;

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic [CW:0]        inflight_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;

    // Credit check: never have more words stored or in flight than FIFO slots,
    // so a returning word always finds room.
    always_comb begin
        inflight_s = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
        issue_s    = !reset && !bus.should_jump && (inflight_s < (CW+1)'(DEPTH));
        push_s     = pending_q && !bus.should_jump;
        pop_s      = (count_q != {CW{1'b0}}) && bus.dec_ready && !bus.should_jump;
    end

    // Next-state for PC, in-flight tracking and FIFO bookkeeping; a redirect
    // overrides everything and restarts fetch at the target.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (bus.should_jump) begin
            fetch_pc_d = bus.jump_pc;
            pending_d  = 1'b0;
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            pending_d = issue_s;
            if (issue_s) begin
                pending_pc_d = fetch_pc_q;
                fetch_pc_d   = fetch_pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end else begin
                pending_pc_d = pending_pc_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= {PC_W{1'b0}};
            pending_q    <= 1'b0;
            pending_pc_q <= {PC_W{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= {PC_W{1'b0}};
                instr_mem_q[i] <= {INSTR_W{1'b0}};
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]    <= pending_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_data;
        end else begin
            pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
            instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
        end
    end

    // Outputs are the registered head entry and registered PC; only the read
    // strobe depends on the live redirect/reset inputs.
    always_comb begin
        bus.imem_rd_en = issue_s;
        bus.imem_addr  = fetch_pc_q;
        bus.dec_valid  = (count_q != {CW{1'b0}});
        bus.dec_instr  = instr_mem_q[rd_ptr_q];
        bus.dec_pc     = pc_mem_q[rd_ptr_q];
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a directed vector table from reset, then hand-driven
// corner sequences and randomized traffic checked against a queue model.
module tb_fetch_queue;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;
    localparam int NPC     = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    // Synchronous-read instruction memory.
    logic [31:0] imem [NPC];
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_data <= imem[bus.imem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: stored pcs, one optional in-flight read, next fetch pc.
    int mq[$];
    bit m_pend;
    int m_pend_pc;
    int m_fetch;

    typedef struct {
        bit j;
        int jpc;
        bit rdy;
        bit e_rd;
        int e_addr;
        bit e_valid;
        int e_pc;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(bit j, int jpc, bit rdy, bit e_rd, int e_addr, bit e_valid, int e_pc);
        vec_t v;
        v.j = j; v.jpc = jpc; v.rdy = rdy;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend    = 1'b0;
        m_pend_pc = 0;
        m_fetch   = 0;
    endtask

    task automatic drive(input bit j, input int jpc, input bit rdy);
        bus.should_jump = j;
        bus.jump_pc     = PC_W'(jpc);
        bus.dec_ready   = rdy;
    endtask

    // One cycle against the model; entered and left just after a falling edge.
    task automatic step(input bit j, input int jpc, input bit rdy);
        bit e_rd;
        bit e_valid;
        drive(j, jpc, rdy);
        #1;
        e_rd    = !j && ((mq.size() + int'(m_pend)) < DEPTH);
        e_valid = (mq.size() != 0);
        chk("rd_en", {31'b0, bus.imem_rd_en}, {31'b0, e_rd});
        chk("addr", {27'b0, bus.imem_addr}, 32'(m_fetch));
        chk("dec_valid", {31'b0, bus.dec_valid}, {31'b0, e_valid});
        if (e_valid) begin
            chk("dec_pc", {27'b0, bus.dec_pc}, 32'(mq[0]));
            chk("dec_instr", bus.dec_instr, 32'h1000_0000 + 32'(mq[0]));
        end
        chk("no_overflow", {31'b0, (dut.pending_q && !j && (int'(dut.count_q) == DEPTH))}, 32'd0);
        if (j) begin
            mq.delete();
            m_pend  = 1'b0;
            m_fetch = jpc;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
            m_pend = e_rd;
            if (e_rd) begin
                m_pend_pc = m_fetch;
                m_fetch   = (m_fetch + 1) % NPC;
            end
        end
        @(negedge clk);
    endtask

    // Table-vector cycle with hand-derived expectations.
    task automatic step_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        drive(v.j, v.jpc, v.rdy);
        #1;
        chk("vec_rd_en", {31'b0, bus.imem_rd_en}, {31'b0, v.e_rd});
        chk("vec_addr", {27'b0, bus.imem_addr}, 32'(v.e_addr));
        chk("vec_valid", {31'b0, bus.dec_valid}, {31'b0, v.e_valid});
        if (v.e_valid) begin
            chk("vec_pc", {27'b0, bus.dec_pc}, 32'(v.e_pc));
            chk("vec_instr", bus.dec_instr, 32'h1000_0000 + 32'(v.e_pc));
        end
        @(negedge clk);
    endtask

    // Assert reset between edges, check outputs clear at once, then release.
    task automatic do_reset();
        drive(1'b0, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
        chk("rst_addr", {27'b0, bus.imem_addr}, 32'd0);
        chk("rst_valid", {31'b0, bus.dec_valid}, 32'd0);
        chk("rst_pc", {27'b0, bus.dec_pc}, 32'd0);
        chk("rst_instr", bus.dec_instr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < NPC; i++) imem[i] = 32'h1000_0000 + 32'(i);

        // Stall from reset, drain, then a redirect taken while decode is ready.
        tbl[0]  = mk(1'b0, 0,  1'b0, 1'b1, 0,  1'b0, 0);
        tbl[1]  = mk(1'b0, 0,  1'b0, 1'b1, 1,  1'b0, 0);
        tbl[2]  = mk(1'b0, 0,  1'b0, 1'b1, 2,  1'b1, 0);
        tbl[3]  = mk(1'b0, 0,  1'b0, 1'b1, 3,  1'b1, 0);
        tbl[4]  = mk(1'b0, 0,  1'b0, 1'b0, 4,  1'b1, 0);
        tbl[5]  = mk(1'b0, 0,  1'b0, 1'b0, 4,  1'b1, 0);
        tbl[6]  = mk(1'b0, 0,  1'b0, 1'b0, 4,  1'b1, 0);
        tbl[7]  = mk(1'b0, 0,  1'b0, 1'b0, 4,  1'b1, 0);
        tbl[8]  = mk(1'b0, 0,  1'b0, 1'b0, 4,  1'b1, 0);
        tbl[9]  = mk(1'b0, 0,  1'b0, 1'b0, 4,  1'b1, 0);
        tbl[10] = mk(1'b0, 0,  1'b1, 1'b0, 4,  1'b1, 0);
        tbl[11] = mk(1'b0, 0,  1'b1, 1'b1, 4,  1'b1, 1);
        tbl[12] = mk(1'b0, 0,  1'b1, 1'b1, 5,  1'b1, 2);
        tbl[13] = mk(1'b0, 0,  1'b1, 1'b1, 6,  1'b1, 3);
        tbl[14] = mk(1'b0, 0,  1'b1, 1'b1, 7,  1'b1, 4);
        tbl[15] = mk(1'b0, 0,  1'b1, 1'b1, 8,  1'b1, 5);
        tbl[16] = mk(1'b1, 20, 1'b1, 1'b0, 9,  1'b1, 6);
        tbl[17] = mk(1'b0, 0,  1'b1, 1'b1, 20, 1'b0, 0);
        tbl[18] = mk(1'b0, 0,  1'b1, 1'b1, 21, 1'b0, 0);
        tbl[19] = mk(1'b0, 0,  1'b1, 1'b1, 22, 1'b1, 20);

        rst = 1'b1;
        drive(1'b0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
        chk("init_valid", {31'b0, bus.dec_valid}, 32'd0);
        chk("init_pc", {27'b0, bus.dec_pc}, 32'd0);
        chk("init_instr", bus.dec_instr, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) step_vec(i);

        // Free-run across the 31 -> 0 wrap.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b1);

        // Redirect to the top of the PC space, then back-to-back redirects.
        step(1'b1, 31, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
        step(1'b1, 20, 1'b1);
        step(1'b1, 31, 1'b0);
        step(1'b1, 3, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

        // Reset while three entries are stored and a read is in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(15) == 0, int'($urandom_range(31)), $urandom_range(9) < 7);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
